// File: rtl/pu_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : pu_controller_if
//  Description : Control/address bundle between the PU sequencer and the
//                memories / datapath it drives.
//  Revision    : 1.0  initial release
// ============================================================================
interface pu_controller_if #(
    parameter int NUM_GROUPS  = 4,
    parameter int NUM_NEURONS = 4
);
    localparam int GW = (NUM_GROUPS  > 1) ? $clog2(NUM_GROUPS)  : 1;
    localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int WW = (NUM_GROUPS * NUM_NEURONS > 1) ? $clog2(NUM_GROUPS * NUM_NEURONS) : 1;

    logic          start;
    logic [GW-1:0] x_addr;
    logic [WW-1:0] w_addr;
    logic          mult_write;
    logic          acc_first;
    logic          acc_en;
    logic          out_write;
    logic [NW-1:0] out_addr;
    logic          busy;
    logic          done;

    // Sequencer side
    modport master (
        input  start,
        output x_addr, w_addr, mult_write, acc_first, acc_en,
        output out_write, out_addr, busy, done
    );

    // Datapath / memory side
    modport slave (
        output start,
        input  x_addr, w_addr, mult_write, acc_first, acc_en,
        input  out_write, out_addr, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/pu_controller.sv
`default_nettype none
// ============================================================================
//  Module      : pu_controller
//  Description : Sequencer for a processing unit. For each neuron it walks
//                all input groups through FETCH -> MULT -> ACC, then stores
//                the neuron result; a run ends with a one-cycle done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module pu_controller #(
    parameter int NUM_GROUPS  = 4,
    parameter int NUM_NEURONS = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,     // asynchronous, active-low
    pu_controller_if.master bus
);
    localparam int GW = (NUM_GROUPS  > 1) ? $clog2(NUM_GROUPS)  : 1;
    localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int WW = (NUM_GROUPS * NUM_NEURONS > 1) ? $clog2(NUM_GROUPS * NUM_NEURONS) : 1;

    localparam logic [GW-1:0] c_group_last  = GW'(NUM_GROUPS - 1);
    localparam logic [NW-1:0] c_neuron_last = NW'(NUM_NEURONS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_MULT  = 3'd2;
    localparam logic [2:0] S_ACC   = 3'd3;
    localparam logic [2:0] S_STORE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]    r_state;
    logic [2:0]    w_state_next;
    logic [GW-1:0] r_group;
    logic [NW-1:0] r_neuron;

    logic w_group_last;
    logic w_neuron_last;

    assign w_group_last  = (r_group  == c_group_last);
    assign w_neuron_last = (r_neuron == c_neuron_last);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Group/neuron counters; last-index tests gate every increment so no wrap occurs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_group  <= '0;
            r_neuron <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_group  <= '0;
                    r_neuron <= '0;
                end
                S_ACC: begin
                    if (!w_group_last) begin
                        r_group <= r_group + GW'(1);
                    end
                end
                S_STORE: begin
                    if (!w_neuron_last) begin
                        r_neuron <= r_neuron + NW'(1);
                        r_group  <= '0;
                    end
                end
                S_DONE: begin
                    r_group  <= '0;
                    r_neuron <= '0;
                end
                default: begin
                    r_group  <= r_group;
                    r_neuron <= r_neuron;
                end
            endcase
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = bus.start ? S_FETCH : S_IDLE;
            S_FETCH: w_state_next = S_MULT;
            S_MULT:  w_state_next = S_ACC;
            S_ACC:   w_state_next = w_group_last ? S_STORE : S_FETCH;
            S_STORE: w_state_next = w_neuron_last ? S_DONE : S_FETCH;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output decode from registered state and counters only
    always_comb begin
        bus.mult_write = 1'b0;
        bus.acc_en     = 1'b0;
        bus.acc_first  = 1'b0;
        bus.out_write  = 1'b0;
        bus.done       = 1'b0;
        bus.busy       = (r_state != S_IDLE);
        bus.x_addr     = r_group;
        bus.w_addr     = WW'(r_neuron) * WW'(NUM_GROUPS) + WW'(r_group);
        bus.out_addr   = r_neuron;
        case (r_state)
            S_MULT:  bus.mult_write = 1'b1;
            S_ACC: begin
                bus.acc_en    = 1'b1;
                bus.acc_first = (r_group == '0);
            end
            S_STORE: bus.out_write = 1'b1;
            S_DONE:  bus.done      = 1'b1;
            default: bus.mult_write = 1'b0;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_pu_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pu_controller
//  Description : Scoreboard bench for pu_controller (default 4x4 instance and
//                a 1x1 instance).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pu_controller;
    localparam int G = 4;
    localparam int N = 4;
    localparam int RUN_CYC = N * (3 * G + 1);   // 52

    // kind: 1 MULT, 2 ACC, 3 STORE, 4 DONE ; -1 = don't care
    typedef struct {
        int kind;
        int xa;
        int wa;
        int first;
        int oa;
        int dt;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   npass = 0;
    int   ntotal = 0;

    ev_t q0[$];
    ev_t q1[$];

    pu_controller_if #(.NUM_GROUPS(G), .NUM_NEURONS(N)) bus0 ();
    pu_controller_if #(.NUM_GROUPS(1), .NUM_NEURONS(1)) bus1 ();

    pu_controller #(.NUM_GROUPS(G), .NUM_NEURONS(N)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    pu_controller #(.NUM_GROUPS(1), .NUM_NEURONS(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        ntotal++;
        if (got == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    function automatic ev_t mk(input int k, input int xa, input int wa,
                               input int first, input int oa, input int dt);
        ev_t e;
        e.kind = k; e.xa = xa; e.wa = wa; e.first = first; e.oa = oa; e.dt = dt;
        return e;
    endfunction

    task automatic cmp_ev(input string tag, input ev_t got, input ev_t exp);
        chk({tag, "_kind"}, got.kind, exp.kind);
        if (exp.xa    >= 0) chk({tag, "_x_addr"},    got.xa,    exp.xa);
        if (exp.wa    >= 0) chk({tag, "_w_addr"},    got.wa,    exp.wa);
        if (exp.first >= 0) chk({tag, "_acc_first"}, got.first, exp.first);
        if (exp.oa    >= 0) chk({tag, "_out_addr"},  got.oa,    exp.oa);
        if (exp.dt    >= 0) chk({tag, "_done_lat"},  got.dt,    exp.dt);
    endtask

    // Expected event stream of one full default run
    task automatic push_run0();
        for (int n = 0; n < N; n++) begin
            for (int g = 0; g < G; g++) begin
                q0.push_back(mk(1, g, n * G + g, -1, -1, -1));
                q0.push_back(mk(2, g, n * G + g, (g == 0) ? 1 : 0, -1, -1));
            end
            q0.push_back(mk(3, -1, -1, -1, n, -1));
        end
        q0.push_back(mk(4, -1, -1, -1, -1, RUN_CYC));
    endtask

    // Monitor for the default instance
    initial begin : mon0
        int   start_cyc;
        logic prev_busy;
        int   nstb;
        ev_t  got;
        ev_t  exp;
        start_cyc = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (bus0.busy && !prev_busy) start_cyc = cyc;
                prev_busy = bus0.busy;
                nstb = int'(bus0.mult_write) + int'(bus0.acc_en) + int'(bus0.out_write) + int'(bus0.done);
                if (bus0.acc_first && !bus0.acc_en) chk("m0_acc_first_alone", 1, 0);
                if (nstb > 1) chk("m0_strobe_count", nstb, 1);
                else if (nstb == 1) begin
                    got.kind  = bus0.mult_write ? 1 : bus0.acc_en ? 2 : bus0.out_write ? 3 : 4;
                    got.xa    = int'(bus0.x_addr);
                    got.wa    = int'(bus0.w_addr);
                    got.first = int'(bus0.acc_first);
                    got.oa    = int'(bus0.out_addr);
                    got.dt    = cyc - start_cyc;
                    if (q0.size() == 0) chk("m0_unexpected_event", got.kind, 0);
                    else begin
                        exp = q0.pop_front();
                        cmp_ev("m0", got, exp);
                    end
                end
            end else begin
                prev_busy = 1'b0;
            end
        end
    end

    // Monitor for the 1x1 instance
    initial begin : mon1
        int   start_cyc;
        logic prev_busy;
        int   nstb;
        ev_t  got;
        ev_t  exp;
        start_cyc = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (bus1.busy && !prev_busy) start_cyc = cyc;
                prev_busy = bus1.busy;
                nstb = int'(bus1.mult_write) + int'(bus1.acc_en) + int'(bus1.out_write) + int'(bus1.done);
                if (nstb > 1) chk("m1_strobe_count", nstb, 1);
                else if (nstb == 1) begin
                    got.kind  = bus1.mult_write ? 1 : bus1.acc_en ? 2 : bus1.out_write ? 3 : 4;
                    got.xa    = int'(bus1.x_addr);
                    got.wa    = int'(bus1.w_addr);
                    got.first = int'(bus1.acc_first);
                    got.oa    = int'(bus1.out_addr);
                    got.dt    = cyc - start_cyc;
                    if (q1.size() == 0) chk("m1_unexpected_event", got.kind, 0);
                    else begin
                        exp = q1.pop_front();
                        cmp_ev("m1", got, exp);
                    end
                end
            end else begin
                prev_busy = 1'b0;
            end
        end
    end

    task automatic pulse_start0();
        @(posedge clk); #1 bus0.start = 1'b1;
        @(posedge clk); #1 bus0.start = 1'b0;
        chk("fetch_after_start_busy", int'(bus0.busy), 1);
        chk("fetch_after_start_mult", int'(bus0.mult_write), 0);
    endtask

    task automatic wait_done0(input string name);
        int k;
        k = 0;
        while (!bus0.done && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!bus0.done) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic check_all_zero0(input string name);
        chk({name, "_busy"},       int'(bus0.busy),       0);
        chk({name, "_mult_write"}, int'(bus0.mult_write), 0);
        chk({name, "_acc_en"},     int'(bus0.acc_en),     0);
        chk({name, "_acc_first"},  int'(bus0.acc_first),  0);
        chk({name, "_out_write"},  int'(bus0.out_write),  0);
        chk({name, "_done"},       int'(bus0.done),       0);
        chk({name, "_x_addr"},     int'(bus0.x_addr),     0);
        chk({name, "_w_addr"},     int'(bus0.w_addr),     0);
        chk({name, "_out_addr"},   int'(bus0.out_addr),   0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int k;
        bus0.start = 1'b0;
        bus1.start = 1'b0;

        // Reset state
        #12;
        check_all_zero0("reset");
        chk("reset_busy1", int'(bus1.busy), 0);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero0("idle");

        // Plain run: 52-cycle latency, full address sequence
        push_run0();
        pulse_start0();
        wait_done0("run1");

        // start re-pulsed during the run is ignored
        push_run0();
        pulse_start0();
        repeat (4) @(posedge clk);
        #1 bus0.start = 1'b1;
        @(posedge clk); #1 bus0.start = 1'b0;
        repeat (24) @(posedge clk);
        #1 bus0.start = 1'b1;
        @(posedge clk); #1 bus0.start = 1'b0;
        wait_done0("run2");
        repeat (3) @(negedge clk);
        chk("no_queued_start_busy", int'(bus0.busy), 0);

        // Asynchronous reset during neuron 2 ACC
        push_run0();
        pulse_start0();
        k = 0;
        while (!(bus0.acc_en && bus0.out_addr == 2'd2) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("reach_neuron2_acc", int'(bus0.acc_en), 1);
        #2 rst = 1'b0;
        #1;
        check_all_zero0("async_rst");
        q0.delete();
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle_busy", int'(bus0.busy), 0);
        push_run0();
        pulse_start0();
        wait_done0("run3");

        // start held high: back-to-back runs with one IDLE cycle between
        push_run0();
        push_run0();
        @(posedge clk); #1 bus0.start = 1'b1;
        wait_done0("run4a");
        @(negedge clk);
        chk("b2b_idle_gap", int'(bus0.busy), 0);
        @(negedge clk);
        chk("b2b_restart", int'(bus0.busy), 1);
        bus0.start = 1'b0;
        @(negedge clk);
        wait_done0("run4b");
        repeat (3) @(negedge clk);

        // Single group, single neuron instance
        q1.push_back(mk(1, 0, 0, -1, -1, -1));
        q1.push_back(mk(2, 0, 0,  1, -1, -1));
        q1.push_back(mk(3, -1, -1, -1, 0, -1));
        q1.push_back(mk(4, -1, -1, -1, -1, 4));
        @(posedge clk); #1 bus1.start = 1'b1;
        @(posedge clk); #1 bus1.start = 1'b0;
        chk("g1_fetch_busy", int'(bus1.busy), 1);
        k = 0;
        while (!bus1.done && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!bus1.done) chk("g1_done_timeout", 0, 1);
        repeat (3) @(negedge clk);

        chk("sb0_drain", q0.size(), 0);
        chk("sb1_drain", q1.size(), 0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pu_controller.md
PU_CONTROLLER -- requirements
Module: pu_controller

Interface
REQ-001 Parameter NUM_GROUPS, default 4, number of 4-input chunks (x/w quadruples) per neuron; shall be >= 1.
REQ-002 Parameter NUM_NEURONS, default 4, number of neurons per run; shall be >= 1.
REQ-003 Derived widths: GW = max(1, ceil(log2 NUM_GROUPS)); NW = max(1, ceil(log2 NUM_NEURONS)); WW = max(1, ceil(log2 (NUM_GROUPS*NUM_NEURONS))).
REQ-004 The block shall use one clock, and reset shall be asynchronous and active-low.
REQ-005 clk  input  1  system clock; all state changes on rising edge.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 start  input  1  run request, sampled only in IDLE.
REQ-008 x_addr  output  GW  input-vector memory address (group index).
REQ-009 w_addr  output  WW  weight memory address = neuron*NUM_GROUPS + group.
REQ-010 mult_write  output  1  load enable for the PU product register bank.
REQ-011 acc_first  output  1  with acc_en: accumulator loads PU sum instead of adding.
REQ-012 acc_en  output  1  accumulator capture enable for the PU sum output.
REQ-013 out_write  output  1  write enable for neuron result memory.
REQ-014 out_addr  output  NW  result memory address (current neuron index).
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse marking run completion.

Function
REQ-017 FSM states: IDLE, FETCH, MULT, ACC, STORE, DONE; internal counters group (0..NUM_GROUPS-1) and neuron (0..NUM_NEURONS-1).
REQ-018 IDLE: start=1 -> FETCH with group=0, neuron=0; start=0 -> stay IDLE.
REQ-019 FETCH (1 cycle): x_addr/w_addr driven from counters (synchronous-read memories, data valid next cycle) -> MULT.
REQ-020 MULT (1 cycle): mult_write=1, addresses held -> ACC.
REQ-021 ACC (1 cycle): acc_en=1; acc_first=1 iff group==0 -> if group<NUM_GROUPS-1: group+1, FETCH; else STORE.
REQ-022 STORE (1 cycle): out_write=1, out_addr=neuron -> if neuron<NUM_NEURONS-1: neuron+1, group=0, FETCH; else DONE.
REQ-023 DONE (1 cycle): done=1 -> IDLE; counters cleared to 0.
REQ-024 mult_write, acc_en, acc_first, out_write, done shall be 0 in every state not listed as asserting them.
REQ-025 Outputs shall be decoded from registered state/counters only (no combinational path from start to any output).
REQ-026 x_addr = group and w_addr = neuron*NUM_GROUPS + group in all states; out_addr = neuron in all states.
REQ-027 Latency: per neuron 3*NUM_GROUPS+1 cycles; done asserted NUM_NEURONS*(3*NUM_GROUPS+1) cycles after the first FETCH cycle.
REQ-028 start asserted while busy=1 shall be ignored and not queued; start held high in DONE does not start a run until IDLE samples it.
REQ-029 Counters shall never exceed their maximum; no wrap occurs within a run (last-index checks precede increment).
REQ-030 NUM_GROUPS=1: every ACC asserts acc_first; NUM_NEURONS=1: STORE goes directly to DONE.

Reset
REQ-031 rst=0 at any time, including mid-run, shall force IDLE, group=0, neuron=0 and all outputs to 0 immediately (asynchronously).
REQ-032 After rst deasserts, the block shall wait in IDLE for a new start; no partial run resumes.

Verification
REQ-033 Defaults, start pulse 1 cycle -> FETCH next cycle; done high exactly 52 cycles after first FETCH; exactly 16 mult_write, 16 acc_en, 4 acc_first, 4 out_write pulses.
REQ-034 Defaults, monitor addresses at each mult_write -> (x_addr,w_addr) sequence (0,0),(1,1),(2,2),(3,3),(0,4)...(3,15); out_addr 0,1,2,3 at out_write.
REQ-035 start re-pulsed at cycles 5 and 30 of a run -> no effect; done count stays 1 and cycle count 52.
REQ-036 rst low during neuron 2 ACC -> all outputs 0 in same cycle, busy=0; new start after release -> full 52-cycle run from neuron 0.
REQ-037 NUM_GROUPS=1, NUM_NEURONS=1, start -> FETCH, MULT, ACC (acc_first=1), STORE (out_addr=0), DONE; done 4 cycles after FETCH.
REQ-038 start held high continuously -> back-to-back runs separated by one IDLE cycle after each DONE.
